// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the two-source UART transmit arbiter.
// Optional source-tag headers are enabled with UART_ARB_TAG_EN.
package uart_arb_pkg;

  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] TAG_BASE = 8'hF0;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
`ifdef UART_ARB_TAG_EN
    ,
    HDR_ISSUE,
    HDR_WAIT
`endif
  } arb_state_e;

  // Strict alternation when both sources are pending.
  function automatic logic arb_pick(input logic ne0, input logic ne1, input logic last_src);
    if (ne0 && ne1) begin
      return ~last_src;
    end
    return ne0 ? 1'b0 : 1'b1;
  endfunction

  function automatic logic [BYTE_W-1:0] tag_byte(input logic src);
    return TAG_BASE | {{(BYTE_W-1){1'b0}}, src};
  endfunction

endpackage

// File: rtl/arb_byte_fifo.sv
// Small byte FIFO for one arbiter requester; full/empty come straight
// from the registered occupancy count.
module arb_byte_fifo
  import uart_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [BYTE_W-1:0] wdata,
  input  logic              pop,
  output logic [BYTE_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  // A full FIFO refuses a push even when a pop happens in the same cycle.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter between two byte FIFOs.
// Define UART_ARB_TAG_EN to prefix each change of source with a tag byte.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic              CLK,
  input  logic              XRST,
  input  logic [BYTE_W-1:0] req0_data,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [BYTE_W-1:0] req1_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_go,
  input  logic              tx_busy,
  output logic              grant_src,
  output logic              timeout_err
);

  localparam int CNT_W = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

  arb_state_e        state;
  arb_state_e        state_nxt;
  logic [BYTE_W-1:0] tx_data_nxt;
  logic              grant_nxt;
  logic              err_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;

  logic [BYTE_W-1:0] rdata0;
  logic [BYTE_W-1:0] rdata1;
  logic              full0;
  logic              full1;
  logic              empty0;
  logic              empty1;
  logic              pop0;
  logic              pop1;
  logic              sel;
  logic [BYTE_W-1:0] head;

`ifdef UART_ARB_TAG_EN
  logic hdr_pend;
  logic hdr_pend_nxt;
  logic tag_valid;
  logic tag_valid_nxt;
`endif

  arb_byte_fifo #(.DEPTH(DEPTH)) u_fifo0 (
    .clk   (CLK),
    .rst_n (XRST),
    .push  (req0_valid),
    .wdata (req0_data),
    .pop   (pop0),
    .rdata (rdata0),
    .full  (full0),
    .empty (empty0)
  );

  arb_byte_fifo #(.DEPTH(DEPTH)) u_fifo1 (
    .clk   (CLK),
    .rst_n (XRST),
    .push  (req1_valid),
    .wdata (req1_data),
    .pop   (pop1),
    .rdata (rdata1),
    .full  (full1),
    .empty (empty1)
  );

  assign req0_ready = !full0;
  assign req1_ready = !full1;
  assign sel        = arb_pick(!empty0, !empty1, grant_src);
  assign head       = sel ? rdata1 : rdata0;

`ifdef UART_ARB_TAG_EN
  assign tx_go = (state == ISSUE) || (state == HDR_ISSUE);
`else
  assign tx_go = (state == ISSUE);
`endif

  always_ff @(posedge CLK or negedge XRST) begin
    if (!XRST) begin
      state       <= IDLE;
      tx_data     <= '0;
      grant_src   <= 1'b1;
      timeout_err <= 1'b0;
      cnt         <= '0;
`ifdef UART_ARB_TAG_EN
      hdr_pend    <= 1'b0;
      tag_valid   <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      tx_data     <= tx_data_nxt;
      grant_src   <= grant_nxt;
      timeout_err <= err_nxt;
      cnt         <= cnt_nxt;
`ifdef UART_ARB_TAG_EN
      hdr_pend    <= hdr_pend_nxt;
      tag_valid   <= tag_valid_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt     = state;
    tx_data_nxt   = tx_data;
    grant_nxt     = grant_src;
    err_nxt       = timeout_err;
    cnt_nxt       = cnt;
    pop0          = 1'b0;
    pop1          = 1'b0;
`ifdef UART_ARB_TAG_EN
    hdr_pend_nxt  = hdr_pend;
    tag_valid_nxt = tag_valid;
`endif

    case (state)
      IDLE: begin
        if (!empty0 || !empty1) begin
          grant_nxt = sel;
`ifdef UART_ARB_TAG_EN
          if (!tag_valid || (sel != grant_src)) begin
            tx_data_nxt = tag_byte(sel);
            state_nxt   = HDR_ISSUE;
          end else begin
            pop0        = !sel;
            pop1        = sel;
            tx_data_nxt = head;
            state_nxt   = ISSUE;
          end
`else
          pop0        = !sel;
          pop1        = sel;
          tx_data_nxt = head;
          state_nxt   = ISSUE;
`endif
        end
      end

      ISSUE: begin
        cnt_nxt   = '0;
        state_nxt = WAIT_BUSY;
      end

      WAIT_BUSY: begin
        if (tx_busy) begin
          state_nxt = WAIT_DONE;
        end else if (cnt == CNT_LAST) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      WAIT_DONE: begin
        if (!tx_busy) begin
`ifdef UART_ARB_TAG_EN
          // Header finished: the data byte of the granted source follows.
          if (hdr_pend) begin
            hdr_pend_nxt = 1'b0;
            pop0         = !grant_src;
            pop1         = grant_src;
            tx_data_nxt  = grant_src ? rdata1 : rdata0;
            state_nxt    = ISSUE;
          end else begin
            state_nxt = IDLE;
          end
`else
          state_nxt = IDLE;
`endif
        end
      end

`ifdef UART_ARB_TAG_EN
      HDR_ISSUE: begin
        cnt_nxt   = '0;
        state_nxt = HDR_WAIT;
      end

      HDR_WAIT: begin
        if (tx_busy) begin
          hdr_pend_nxt  = 1'b1;
          tag_valid_nxt = 1'b1;
          state_nxt     = WAIT_DONE;
        end else if (cnt == CNT_LAST) begin
          // The whole tagged transfer is dropped; the next byte re-tags.
          err_nxt       = 1'b1;
          tag_valid_nxt = 1'b0;
          pop0          = !grant_src;
          pop1          = grant_src;
          state_nxt     = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
`endif

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scoreboard bench for uart_tx_arbiter with a simple transmitter model.
module tb_uart_tx_arbiter;

  logic       CLK = 1'b0;
  logic       XRST = 1'b1;
  logic [7:0] req0_data = 8'h00;
  logic [7:0] req1_data = 8'h00;
  logic       req0_valid = 1'b0;
  logic       req1_valid = 1'b0;
  logic       req0_ready;
  logic       req1_ready;
  logic [7:0] tx_data;
  logic       tx_go;
  logic       tx_busy;
  logic       grant_src;
  logic       timeout_err;

  logic       busy_force = 1'b0;
  logic       busy_model = 1'b0;
  logic       resp_en = 1'b1;
  int         hold = 20;
  int         resp_phase = 0;
  int         resp_cnt = 0;

  logic [8:0] got_mem [64];
  int         go_cnt = 0;
  logic       go_prev = 1'b0;
  logic       go_long = 1'b0;

  logic [8:0] exp_q [$];
  int         rd_idx = 0;
  int         tests = 0;
  int         fails = 0;
`ifdef UART_ARB_TAG_EN
  logic       exp_tag_valid = 1'b0;
  logic       exp_last = 1'b1;
`endif

  assign tx_busy = busy_force | busy_model;

  uart_tx_arbiter #(.DEPTH(4), .BUSY_TIMEOUT(16)) dut (
    .CLK         (CLK),
    .XRST        (XRST),
    .req0_data   (req0_data),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req1_data   (req1_data),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .tx_data     (tx_data),
    .tx_go       (tx_go),
    .tx_busy     (tx_busy),
    .grant_src   (grant_src),
    .timeout_err (timeout_err)
  );

  always #5 CLK = ~CLK;

  // Transmitter model: busy rises one cycle after go and stays up for hold cycles.
  always @(negedge CLK) begin
    if (resp_phase == 0) begin
      if (tx_go && resp_en) resp_phase <= 1;
    end else if (resp_phase == 1) begin
      busy_model <= 1'b1;
      resp_cnt   <= hold - 1;
      resp_phase <= 2;
    end else begin
      if (resp_cnt == 0) begin
        busy_model <= 1'b0;
        resp_phase <= 0;
      end else begin
        resp_cnt <= resp_cnt - 1;
      end
    end
  end

  always @(negedge CLK) begin
    if (tx_go === 1'b1) begin
      if (go_cnt < 64) got_mem[go_cnt] <= {grant_src, tx_data};
      go_cnt <= go_cnt + 1;
      if (go_prev) go_long <= 1'b1;
    end
    go_prev <= (tx_go === 1'b1);
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic exp_push(input logic src, input logic [7:0] d);
`ifdef UART_ARB_TAG_EN
    if (!exp_tag_valid || (src != exp_last)) exp_q.push_back({src, 8'hF0 | {7'b0, src}});
    exp_tag_valid = 1'b1;
    exp_last      = src;
`endif
    exp_q.push_back({src, d});
  endtask

  task automatic push(input logic src, input logic [7:0] d);
    if (src) begin
      chk("push1_ready", req1_ready, 1);
      req1_data  = d;
      req1_valid = 1'b1;
    end else begin
      chk("push0_ready", req0_ready, 1);
      req0_data  = d;
      req0_valid = 1'b1;
    end
    step(1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic check_issues(input string tag, input int budget);
    int n;
    logic [8:0] e;
    n = 0;
    while (((go_cnt - rd_idx) < exp_q.size()) && (n < budget)) begin
      step(1);
      n++;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rd_idx < go_cnt) begin
        chk(tag, got_mem[rd_idx], e);
        rd_idx++;
      end else begin
        chk({tag, "_missing"}, 9'bx, e);
      end
    end
  endtask

  task automatic wait_quiet(input int budget);
    int n;
    n = 0;
    while ((tx_busy || resp_phase != 0) && n < budget) begin
      step(1);
      n++;
    end
    chk("quiet_reached", (tx_busy == 1'b0 && resp_phase == 0), 1);
    step(3);
  endtask

  task automatic do_reset();
    XRST = 1'b0;
    step(3);
    XRST = 1'b1;
`ifdef UART_ARB_TAG_EN
    exp_tag_valid = 1'b0;
    exp_last      = 1'b1;
`endif
    step(1);
  endtask

  initial begin
    int n;

    // Reset values, during and after reset.
    #1 XRST = 1'b0;
    step(3);
    chk("rst_req0_ready", req0_ready, 1);
    chk("rst_req1_ready", req1_ready, 1);
    chk("rst_tx_go", tx_go, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_grant_src", grant_src, 1);
    chk("rst_timeout_err", timeout_err, 0);
    XRST = 1'b1;
    step(2);
    chk("post_rst_tx_go", tx_go, 0);
    chk("post_rst_ready0", req0_ready, 1);

    // Single byte with a long frame.
    hold = 143;
    exp_push(1'b0, 8'h41);
    push(1'b0, 8'h41);
    check_issues("single_issue", 20);
    chk("single_grant", grant_src, 0);
    wait_quiet(200);
    chk("single_no_err", timeout_err, 0);
    chk("single_go_width", go_long, 0);

    // Contention from reset: strict alternation starting with source 0.
    hold = 20;
    do_reset();
    req0_data = 8'h01; req0_valid = 1'b1;
    req1_data = 8'hA1; req1_valid = 1'b1;
    step(1);
    req0_data = 8'h02;
    req1_data = 8'hA2;
    step(1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    exp_push(1'b0, 8'h01);
    exp_push(1'b1, 8'hA1);
    exp_push(1'b0, 8'h02);
    exp_push(1'b1, 8'hA2);
    check_issues("contend_order", 400);
    wait_quiet(100);

    // FIFO full while the transmitter is held busy.
    exp_push(1'b0, 8'h10);
    push(1'b0, 8'h10);
    n = 0;
    while (((go_cnt - rd_idx) < exp_q.size()) && n < 100) begin
      step(1);
      n++;
    end
    busy_force = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      exp_push(1'b0, 8'h10 + 8'(i));
      push(1'b0, 8'h10 + 8'(i));
    end
    chk("full_ready_low", req0_ready, 0);
    req0_data  = 8'h15;
    req0_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("full_5th_blocked", req0_ready, 0);
    end
    req0_valid = 1'b0;
    busy_force = 1'b0;
    n = 0;
    while (!req0_ready && n < 60) begin
      step(1);
      n++;
    end
    chk("full_ready_back", req0_ready, 1);
    check_issues("full_order", 400);
    wait_quiet(100);
    chk("full_drained", go_cnt - rd_idx, 0);

    // Timeout: transmitter never answers.
    resp_en = 1'b0;
    chk("pre_timeout_err", timeout_err, 0);
    exp_push(1'b0, 8'h55);
    push(1'b0, 8'h55);
    check_issues("timeout_issue", 20);
    step(15);
    chk("timeout_not_yet", timeout_err, 0);
    step(1);
    chk("timeout_set", timeout_err, 1);
    resp_en = 1'b1;
    exp_push(1'b1, 8'h66);
    push(1'b1, 8'h66);
    check_issues("after_timeout", 100);
    chk("timeout_sticky", timeout_err, 1);
    wait_quiet(100);

    // Reset in the middle of a frame with two bytes queued.
    hold = 60;
    exp_push(1'b0, 8'h77);
    push(1'b0, 8'h77);
    check_issues("midrst_issue", 100);
    push(1'b0, 8'h78);
    push(1'b0, 8'h79);
    step(5);
    chk("midrst_busy_high", tx_busy, 1);
    #1 XRST = 1'b0;
    #1;
    chk("midrst_tx_data", tx_data, 8'h00);
    chk("midrst_grant", grant_src, 1);
    chk("midrst_err", timeout_err, 0);
    chk("midrst_tx_go", tx_go, 0);
    chk("midrst_ready0", req0_ready, 1);
    step(3);
    XRST = 1'b1;
`ifdef UART_ARB_TAG_EN
    exp_tag_valid = 1'b0;
    exp_last      = 1'b1;
`endif
    step(80);
    chk("midrst_no_go", go_cnt - rd_idx, 0);
    wait_quiet(100);

    // Requester 1 after reset (tagged builds expect a header first).
    hold = 20;
    exp_push(1'b1, 8'h33);
    push(1'b1, 8'h33);
    check_issues("req1_issue", 100);
    chk("req1_grant", grant_src, 1);
    wait_quiet(100);

    chk("final_no_extra_go", go_cnt - rd_idx, 0);
    chk("final_go_width", go_long, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
